prince_stream_ctrl: RTL and testbench
=====================================

Name: prince_stream_ctrl

Overview:
- Bus-master sequencer directly upstream of the PRINCE register-mapped wrapper.
- Converts a 64-bit valid/ready block stream plus a 128-bit key/mode setting into wrapper register accesses (cs/we/address/write_data), polls the STATUS ready bit, and reads back RESULT0/1.
- Emits each 64-bit result as an output stream.
- Lets datapath logic use the cipher without a CPU.

Parameters:
POLL_DELAY, 2, idle cycles after the CTRL.next write before the first STATUS read (covers the wrapper's registered next and the core's ready drop)
TIMEOUT, 1024, max STATUS reads per block before aborting; range 1..65535

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
key  in  128  cipher key; key[31:0] goes to KEY0 (0x10) … key[127:96] to KEY3 (0x13)
encdec  in  1  mode bit written to CONFIG bit0
cfg_load  in  1  request: write key+encdec to wrapper before the next block
in_valid  in  1  input block valid
in_ready  out  1  input block accepted when in_valid&in_ready
in_block  in  64  plaintext/ciphertext; [31:0] to BLOCK0 (0x20), [63:32] to BLOCK1 (0x21)
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&out_ready
out_block  out  64  {RESULT1,RESULT0}
timeout_err  out  1  sticky; set on poll timeout, cleared by reset only
cs  out  1  wrapper chip select
we  out  1  wrapper write enable
address  out  8  wrapper register address
write_data  out  32  wrapper write data
read_data  in  32  wrapper read data, combinational, same cycle as cs&~we

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_block=0, timeout_err=0, cs=0, we=0, address=0, write_data=0. FSM enters IDLE. cfg_pending=1, so the first block always writes the config.
- Bus outputs are registered. Each FSM state holding cs=1 issues exactly one single-cycle access. Reads sample read_data in the cycle cs=1, we=0 is presented on the registered outputs.
- cfg_load pulse in any state: latches key/encdec into shadow regs and sets cfg_pending. A pulse during an in-flight block affects only later blocks.
- States:
  - IDLE: in_ready=1 and out_valid=0. On handshake, capture in_block. Go to WKEY if cfg_pending, else WBLK.
  - WKEY: 4 cycles writing KEY0..KEY3 (2-bit counter), then WCFG.
  - WCFG: write 0x0a = {31'h0,encdec}; clear cfg_pending; go to WBLK.
  - WBLK: 2 cycles writing 0x20, 0x21.
  - WNEXT: write 0x08 = 32'h1.
  - WAIT: POLL_DELAY cycles with cs=0.
  - POLL: read 0x09 each cycle.
    - bit0=1 → RD0.
    - Otherwise increment poll counter; at TIMEOUT, set timeout_err and go to IDLE, dropping the block (no output).
  - RD0: read 0x30 into out_block[31:0].
  - RD1: read 0x31 into out_block[63:32].
  - OUT: out_valid=1, holding out_block stable until out_ready. Handshake → IDLE. No new input is accepted while OUT.
- One block in flight at a time; in_ready is only high in IDLE.
- Latency, in_valid handshake to out_valid, with cfg write and ready on the first poll: 1+4+1+2+1+POLL_DELAY+1+2 cycles. It is 5 cycles shorter without a cfg write.
- cfg_load simultaneous with an IDLE handshake: the new key applies to that block.
- Reset mid-operation returns to IDLE immediately with all outputs at reset values. The wrapper has its own reset, so no bus cleanup is issued.
- Writes are only issued while the wrapper core is ready: the sequence is serialized behind POLL, and after reset the core is idle.

Decomposition:
- Shared package prince_pkg holds:
  - wrapper address constants: NAME0/1, VERSION, CTRL, STATUS, CONFIG, KEY0..3, BLOCK0/1, RESULT0/1
  - bit indices: CTRL_NEXT, STATUS_READY, CONFIG_ENCDEC
  - FSM state enum
- No sub-module. A single FSM plus counters (key word, wait, poll) fits about 250 lines.

Test Plan:
1. Reset, then cfg_load with key=0 and encdec=1, then in_block=0 → out_block=64'h818665aa0d02dfda. Bus trace shows KEY0..3, CONFIG, BLOCK0/1, CTRL, STATUS reads, RESULT0/1 in order.
2. Second block 64'hffffffffffffffff with no cfg_load → out_block=64'h604ae6ca03c20ada. No KEY/CONFIG writes appear; latency is 5 cycles shorter.
3. cfg_load with encdec=0 and same key, then in_block=64'h818665aa0d02dfda → out_block=0 (decrypt round-trip).
4. Hold out_ready=0 for 20 cycles → out_valid stays 1 with out_block stable, in_ready=0, cs=0 throughout. Release → one transfer, then in_ready=1.
5. Bus model forces STATUS bit0=0 with TIMEOUT=8 → exactly 8 STATUS reads, timeout_err=1, no out_valid, returns to IDLE with in_ready=1.
6. Assert reset during the POLL state → next cycle cs=0, out_valid=0, in_ready=0. After release, the first block re-writes the key (cfg_pending=1).

Source files
------------

// File: rtl/prince_pkg.sv
// Shared definitions for the PRINCE wrapper register map and the stream sequencer.
// Holds the address map, bit positions, the FSM state type and a word-select helper.
package prince_pkg;

   localparam logic [7:0] ADDR_NAME0   = 8'h00;
   localparam logic [7:0] ADDR_NAME1   = 8'h01;
   localparam logic [7:0] ADDR_VERSION = 8'h02;
   localparam logic [7:0] ADDR_CTRL    = 8'h08;
   localparam logic [7:0] ADDR_STATUS  = 8'h09;
   localparam logic [7:0] ADDR_CONFIG  = 8'h0a;
   localparam logic [7:0] ADDR_KEY0    = 8'h10;
   localparam logic [7:0] ADDR_KEY1    = 8'h11;
   localparam logic [7:0] ADDR_KEY2    = 8'h12;
   localparam logic [7:0] ADDR_KEY3    = 8'h13;
   localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
   localparam logic [7:0] ADDR_BLOCK1  = 8'h21;
   localparam logic [7:0] ADDR_RESULT0 = 8'h30;
   localparam logic [7:0] ADDR_RESULT1 = 8'h31;

   localparam int CTRL_NEXT     = 0;
   localparam int STATUS_READY  = 0;
   localparam int CONFIG_ENCDEC = 0;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WKEY,
      S_WCFG,
      S_WBLK,
      S_WNEXT,
      S_WAIT,
      S_POLL,
      S_RD0,
      S_RD1,
      S_OUT
   } state_e;

   // 32-bit word idx of a 128-bit vector, word 0 in the low bits.
   function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] idx);
      return v[{idx, 5'd0} +: 32];
   endfunction

endpackage

// File: rtl/prince_stream_ctrl_if.sv
// Stream, configuration and wrapper-bus signals of the PRINCE stream sequencer.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
// valid holds its data stable until that edge, and ready never waits on anything but state.
interface prince_stream_ctrl_if;
   import prince_pkg::*;

   logic [127:0] key;
   logic         encdec;
   logic         cfg_load;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_block;
   logic         out_valid;
   logic         out_ready;
   logic [63:0]  out_block;
   logic         timeout_err;
   logic         cs;
   logic         we;
   logic [7:0]   address;
   logic [31:0]  write_data;
   logic [31:0]  read_data;
   state_e       dbg_state;

   modport master (
      input  key, encdec, cfg_load, in_valid, in_block, out_ready, read_data,
      output in_ready, out_valid, out_block, timeout_err, cs, we, address, write_data,
      dbg_state
   );

   modport slave (
      output key, encdec, cfg_load, in_valid, in_block, out_ready, read_data,
      input  in_ready, out_valid, out_block, timeout_err, cs, we, address, write_data,
      dbg_state
   );

endinterface

// File: rtl/prince_stream_ctrl.sv
// Sequences one 64-bit block at a time through the PRINCE register wrapper:
// optional key/config writes, block writes, start, status polling and result readback.
module prince_stream_ctrl
   import prince_pkg::*;
#(
   parameter int POLL_DELAY = 2,
   parameter int TIMEOUT    = 1024
) (
   input logic                  clk,
   input logic                  reset,
   prince_stream_ctrl_if.master bus
);

   state_e        state_q, state_d;
   logic [1:0]    kcnt_q, kcnt_d;
   logic [15:0]   wcnt_q, wcnt_d;
   logic [15:0]   pcnt_q, pcnt_d;
   logic [127:0]  key_sh_q, key_sh_d;
   logic          enc_sh_q, enc_sh_d;
   logic          cfg_pending_q, cfg_pending_d;
   logic [127:0]  key_act_q, key_act_d;
   logic          enc_act_q, enc_act_d;
   logic [63:0]   blk_q, blk_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [63:0]   out_block_q, out_block_d;
   logic          timeout_err_q, timeout_err_d;
   logic          cs_q, cs_d;
   logic          we_q, we_d;
   logic [7:0]    address_q, address_d;
   logic [31:0]   write_data_q, write_data_d;
   logic          hs;

   assign hs = bus.in_valid & in_ready_q & (state_q == S_IDLE);

   always_comb begin
      state_d       = state_q;
      kcnt_d        = kcnt_q;
      wcnt_d        = wcnt_q;
      pcnt_d        = pcnt_q;
      key_sh_d      = key_sh_q;
      enc_sh_d      = enc_sh_q;
      cfg_pending_d = cfg_pending_q;
      key_act_d     = key_act_q;
      enc_act_d     = enc_act_q;
      blk_d         = blk_q;
      out_block_d   = out_block_q;
      timeout_err_d = timeout_err_q;

      if (bus.cfg_load) begin
         key_sh_d      = bus.key;
         enc_sh_d      = bus.encdec;
         cfg_pending_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (hs) begin
               // The block snapshots its key here, so later cfg_load pulses only touch later blocks.
               blk_d     = bus.in_block;
               key_act_d = bus.cfg_load ? bus.key : key_sh_q;
               enc_act_d = bus.cfg_load ? bus.encdec : enc_sh_q;
               kcnt_d    = 2'd0;
               if (cfg_pending_q || bus.cfg_load) begin
                  state_d       = S_WKEY;
                  cfg_pending_d = 1'b0;
               end else begin
                  state_d = S_WBLK;
               end
            end
         end
         S_WKEY: begin
            kcnt_d = kcnt_q + 2'd1;
            if (kcnt_q == 2'd3) state_d = S_WCFG;
         end
         S_WCFG: begin
            kcnt_d  = 2'd0;
            state_d = S_WBLK;
         end
         S_WBLK: begin
            if (kcnt_q == 2'd1) begin
               kcnt_d  = 2'd0;
               state_d = S_WNEXT;
            end else begin
               kcnt_d = kcnt_q + 2'd1;
            end
         end
         S_WNEXT: begin
            wcnt_d  = 16'd0;
            pcnt_d  = 16'd0;
            state_d = (POLL_DELAY == 0) ? S_POLL : S_WAIT;
         end
         S_WAIT: begin
            if (wcnt_q == 16'(POLL_DELAY - 1)) state_d = S_POLL;
            else                               wcnt_d  = wcnt_q + 16'd1;
         end
         S_POLL: begin
            if (bus.read_data[STATUS_READY]) begin
               state_d = S_RD0;
            end else if (pcnt_q == 16'(TIMEOUT - 1)) begin
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end else begin
               pcnt_d = pcnt_q + 16'd1;
            end
         end
         S_RD0: begin
            out_block_d[31:0] = bus.read_data;
            state_d           = S_RD1;
         end
         S_RD1: begin
            out_block_d[63:32] = bus.read_data;
            state_d            = S_OUT;
         end
         S_OUT: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Registered outputs are decoded from the next state so they line up with state_q.
      in_ready_d   = (state_d == S_IDLE);
      out_valid_d  = (state_d == S_OUT);
      cs_d         = 1'b0;
      we_d         = 1'b0;
      address_d    = 8'h00;
      write_data_d = 32'h0;
      case (state_d)
         S_WKEY: begin
            cs_d         = 1'b1;
            we_d         = 1'b1;
            address_d    = ADDR_KEY0 + {6'd0, kcnt_d};
            write_data_d = word_of(key_act_d, kcnt_d);
         end
         S_WCFG: begin
            cs_d                        = 1'b1;
            we_d                        = 1'b1;
            address_d                   = ADDR_CONFIG;
            write_data_d[CONFIG_ENCDEC] = enc_act_d;
         end
         S_WBLK: begin
            cs_d         = 1'b1;
            we_d         = 1'b1;
            address_d    = ADDR_BLOCK0 + {7'd0, kcnt_d[0]};
            write_data_d = word_of({64'd0, blk_d}, {1'b0, kcnt_d[0]});
         end
         S_WNEXT: begin
            cs_d                    = 1'b1;
            we_d                    = 1'b1;
            address_d               = ADDR_CTRL;
            write_data_d[CTRL_NEXT] = 1'b1;
         end
         S_POLL: begin
            cs_d      = 1'b1;
            address_d = ADDR_STATUS;
         end
         S_RD0: begin
            cs_d      = 1'b1;
            address_d = ADDR_RESULT0;
         end
         S_RD1: begin
            cs_d      = 1'b1;
            address_d = ADDR_RESULT1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         kcnt_q        <= 2'd0;
         wcnt_q        <= 16'd0;
         pcnt_q        <= 16'd0;
         key_sh_q      <= '0;
         enc_sh_q      <= 1'b0;
         cfg_pending_q <= 1'b1;
         key_act_q     <= '0;
         enc_act_q     <= 1'b0;
         blk_q         <= '0;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         out_block_q   <= '0;
         timeout_err_q <= 1'b0;
         cs_q          <= 1'b0;
         we_q          <= 1'b0;
         address_q     <= 8'h00;
         write_data_q  <= 32'h0;
      end else begin
         state_q       <= state_d;
         kcnt_q        <= kcnt_d;
         wcnt_q        <= wcnt_d;
         pcnt_q        <= pcnt_d;
         key_sh_q      <= key_sh_d;
         enc_sh_q      <= enc_sh_d;
         cfg_pending_q <= cfg_pending_d;
         key_act_q     <= key_act_d;
         enc_act_q     <= enc_act_d;
         blk_q         <= blk_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
         out_block_q   <= out_block_d;
         timeout_err_q <= timeout_err_d;
         cs_q          <= cs_d;
         we_q          <= we_d;
         address_q     <= address_d;
         write_data_q  <= write_data_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_block   = out_block_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.cs          = cs_q;
   assign bus.we          = we_q;
   assign bus.address     = address_q;
   assign bus.write_data  = write_data_q;
   assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_prince_stream_ctrl.sv
// Bench for prince_stream_ctrl: a behavioural wrapper model on the bus side, a
// stream driver, and a scoreboard of expected results derived from the configured key.
module tb_prince_stream_ctrl;
   import prince_pkg::*;

   localparam int PD = 2;
   localparam int TO = 8;
   localparam int LAT_CFG = 1 + 4 + 1 + 2 + 1 + PD + 1 + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   prince_stream_ctrl_if bus();

   prince_stream_ctrl #(.POLL_DELAY(PD), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Stand-in cipher: the three known PRINCE vectors for key 0, otherwise an
   // order-sensitive keyed mix. The sequencer never looks inside the cipher.
   function automatic logic [63:0] fake_core(input logic [127:0] k, input logic [63:0] b,
                                             input logic enc);
      logic [63:0] x;
      if (k == '0 && enc && b == 64'h0) return 64'h818665aa0d02dfda;
      if (k == '0 && enc && b == 64'hffffffffffffffff) return 64'h604ae6ca03c20ada;
      if (k == '0 && !enc && b == 64'h818665aa0d02dfda) return 64'h0;
      x = b;
      for (int i = 0; i < 4; i++) begin
         x = {x[50:0], x[63:51]} ^ {k[i*32 +: 32], ~k[i*32 +: 32]};
         x = x + 64'(i + 1);
      end
      if (!enc) x = ~x ^ 64'h5a5a0f0f3c3ca5a5;
      return x;
   endfunction

   // ---------------- wrapper model ----------------
   logic [31:0] w_key [4];
   logic [31:0] w_cfg;
   logic [31:0] w_blk [2];
   logic [63:0] w_res;
   int          busy_cnt;
   bit          force_stuck = 0;
   bit          busy_rand   = 0;
   int          busy_fix    = 0;
   logic [8:0]  trace_q[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) w_key[i] <= '0;
         w_cfg    <= '0;
         w_blk[0] <= '0;
         w_blk[1] <= '0;
         w_res    <= '0;
         busy_cnt <= 0;
      end else begin
         if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
         if (bus.cs) begin
            trace_q.push_back({bus.we, bus.address});
            if (bus.we) begin
               case (bus.address)
                  ADDR_KEY0:   w_key[0] <= bus.write_data;
                  ADDR_KEY1:   w_key[1] <= bus.write_data;
                  ADDR_KEY2:   w_key[2] <= bus.write_data;
                  ADDR_KEY3:   w_key[3] <= bus.write_data;
                  ADDR_CONFIG: w_cfg    <= bus.write_data;
                  ADDR_BLOCK0: w_blk[0] <= bus.write_data;
                  ADDR_BLOCK1: w_blk[1] <= bus.write_data;
                  ADDR_CTRL: if (bus.write_data[CTRL_NEXT]) begin
                     w_res    <= fake_core({w_key[3], w_key[2], w_key[1], w_key[0]},
                                           {w_blk[1], w_blk[0]}, w_cfg[CONFIG_ENCDEC]);
                     busy_cnt <= busy_rand ? int'($urandom_range(0, 6)) : busy_fix;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      bus.read_data = 32'h0;
      if (bus.cs && !bus.we) begin
         case (bus.address)
            ADDR_NAME0:   bus.read_data = 32'h70726e63;
            ADDR_NAME1:   bus.read_data = 32'h65202020;
            ADDR_VERSION: bus.read_data = 32'h00000001;
            ADDR_STATUS:  bus.read_data[STATUS_READY] = (busy_cnt == 0) && !force_stuck;
            ADDR_RESULT0: bus.read_data = w_res[31:0];
            ADDR_RESULT1: bus.read_data = w_res[63:32];
            default:      bus.read_data = 32'hdeadbeef;
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   logic [63:0]  exp_q[$];
   logic [127:0] tb_key = '0;
   logic         tb_enc = 1'b0;
   int           n_out  = 0;
   logic         prev_stall = 1'b0;
   logic [63:0]  prev_blk;

   always @(negedge clk) begin
      if (!reset) begin
         if (prev_stall) begin
            check_eq("out_hold_valid", 64'(bus.out_valid), 64'd1);
            check_eq("out_hold_block", bus.out_block, prev_blk);
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_blk   = bus.out_block;
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            check_eq("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check_eq("out_block", bus.out_block, exp_q.pop_front());
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   bit rand_bp = 0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_block(input logic [63:0] b, input bit do_cfg, input logic [127:0] k,
                             input logic en, input bit expect_out, output int hs_cyc);
      bit got = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_block = b;
      if (do_cfg) begin
         bus.cfg_load = 1'b1;
         bus.key      = k;
         bus.encdec   = en;
         tb_key       = k;
         tb_enc       = en;
      end
      for (int n = 0; n < 400; n++) begin
         if (bus.in_ready) begin
            got = 1;
            break;
         end
         @(negedge clk);
         bus.cfg_load = 1'b0;
      end
      check_eq("in_handshake", 64'(got), 64'd1);
      hs_cyc = cyc;
      if (got && expect_out) exp_q.push_back(fake_core(tb_key, b, tb_enc));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.cfg_load = 1'b0;
   endtask

   task automatic wait_out(output int seen_cyc);
      bit got = 0;
      seen_cyc = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got      = 1;
            seen_cyc = cyc;
            break;
         end
      end
      check_eq("wait_out_valid", 64'(got), 64'd1);
   endtask

   task automatic check_trace(input string tag, input bit with_cfg, input int polls);
      logic [8:0] e[$];
      if (with_cfg) begin
         for (int i = 0; i < 4; i++) e.push_back({1'b1, ADDR_KEY0 + 8'(i)});
         e.push_back({1'b1, ADDR_CONFIG});
      end
      e.push_back({1'b1, ADDR_BLOCK0});
      e.push_back({1'b1, ADDR_BLOCK1});
      e.push_back({1'b1, ADDR_CTRL});
      for (int i = 0; i < polls; i++) e.push_back({1'b0, ADDR_STATUS});
      e.push_back({1'b0, ADDR_RESULT0});
      e.push_back({1'b0, ADDR_RESULT1});
      check_eq({tag, "_len"}, 64'(trace_q.size()), 64'(e.size()));
      for (int i = 0; i < e.size() && i < trace_q.size(); i++)
         check_eq({tag, "_access"}, 64'(trace_q[i]), 64'(e[i]));
   endtask

   // ---------------- main sequence ----------------
   int          hs, oc, n0, st_reads;
   bit          ok_v, ok_b, ok_r, ok_c, got;
   logic [63:0] b0, rb;
   logic [127:0] rk;

   initial begin
      reset        = 1'b1;
      bus.key      = '0;
      bus.encdec   = 1'b0;
      bus.cfg_load = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_block = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_out_block", bus.out_block, 64'd0);
      check_eq("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
      check_eq("rst_cs", 64'(bus.cs), 64'd0);
      check_eq("rst_we", 64'(bus.we), 64'd0);
      check_eq("rst_address", 64'(bus.address), 64'd0);
      check_eq("rst_write_data", 64'(bus.write_data), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Encrypt zero block under zero key, config written with the block.
      trace_q.delete();
      send_block(64'h0, 1, 128'h0, 1'b1, 1, hs);
      wait_out(oc);
      check_eq("t1_latency", 64'(oc - hs), 64'(LAT_CFG));
      check_eq("t1_result", bus.out_block, 64'h818665aa0d02dfda);
      check_trace("t1_trace", 1, 1);

      // No cfg_load: no key/config writes, five cycles faster.
      trace_q.delete();
      send_block(64'hffffffffffffffff, 0, '0, 1'b0, 1, hs);
      wait_out(oc);
      check_eq("t2_latency", 64'(oc - hs), 64'(LAT_CFG - 5));
      check_eq("t2_result", bus.out_block, 64'h604ae6ca03c20ada);
      check_trace("t2_trace", 0, 1);

      // Decrypt round trip.
      trace_q.delete();
      send_block(64'h818665aa0d02dfda, 1, 128'h0, 1'b0, 1, hs);
      wait_out(oc);
      check_eq("t3_result", bus.out_block, 64'h0);
      check_trace("t3_trace", 1, 1);

      // Output backpressure for 20 cycles.
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      send_block({$urandom, $urandom}, 0, '0, 1'b0, 1, hs);
      wait_out(oc);
      b0 = bus.out_block;
      ok_v = 1; ok_b = 1; ok_r = 1; ok_c = 1;
      repeat (20) begin
         @(negedge clk);
         ok_v &= bus.out_valid;
         ok_b &= (bus.out_block == b0);
         ok_r &= !bus.in_ready;
         ok_c &= !bus.cs;
      end
      check_eq("t4_valid_held", 64'(ok_v), 64'd1);
      check_eq("t4_block_stable", 64'(ok_b), 64'd1);
      check_eq("t4_in_ready_low", 64'(ok_r), 64'd1);
      check_eq("t4_bus_quiet", 64'(ok_c), 64'd1);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_eq("t4_in_ready_after", 64'(bus.in_ready), 64'd1);
      check_eq("t4_out_valid_after", 64'(bus.out_valid), 64'd0);

      // Randomized blocks, keys, core latency, backpressure and mid-flight cfg_load.
      busy_rand = 1;
      rand_bp   = 1;
      for (int i = 0; i < 30; i++) begin
         rb = {$urandom, $urandom};
         rk = {$urandom, $urandom, $urandom, $urandom};
         send_block(rb, ($urandom_range(0, 2) == 0), rk, 1'($urandom_range(0, 1)), 1, hs);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 10)) @(posedge clk);
            #1;
            rk           = {$urandom, $urandom, $urandom, $urandom};
            bus.cfg_load = 1'b1;
            bus.key      = rk;
            bus.encdec   = 1'($urandom_range(0, 1));
            tb_key       = rk;
            tb_enc       = bus.encdec;
            @(posedge clk);
            #1 bus.cfg_load = 1'b0;
         end
      end
      rand_bp   = 0;
      busy_rand = 0;
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
      check_eq("rand_drained", 64'(exp_q.size()), 64'd0);

      // Core never ready: poll timeout.
      force_stuck = 1;
      n0 = n_out;
      @(negedge clk);
      trace_q.delete();
      send_block({$urandom, $urandom}, 0, '0, 1'b0, 0, hs);
      got = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            got = 1;
            break;
         end
      end
      check_eq("t5_back_to_idle", 64'(got), 64'd1);
      st_reads = 0;
      foreach (trace_q[i]) if (trace_q[i] == {1'b0, ADDR_STATUS}) st_reads++;
      check_eq("t5_status_reads", 64'(st_reads), 64'(TO));
      check_eq("t5_timeout_err", 64'(bus.timeout_err), 64'd1);
      check_eq("t5_no_output", 64'(n_out - n0), 64'd0);
      check_eq("t5_out_valid", 64'(bus.out_valid), 64'd0);
      force_stuck = 0;

      // Reset while polling; next block must rewrite the (reset) key.
      busy_fix = 40;
      send_block({$urandom, $urandom}, 0, '0, 1'b0, 0, hs);
      got = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.dbg_state == S_POLL) begin
            got = 1;
            break;
         end
      end
      check_eq("t6_reached_poll", 64'(got), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("t6_cs", 64'(bus.cs), 64'd0);
      check_eq("t6_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("t6_in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("t6_timeout_cleared", 64'(bus.timeout_err), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      busy_fix = 0;
      tb_key   = '0;
      tb_enc   = 1'b0;
      trace_q.delete();
      send_block({$urandom, $urandom}, 0, '0, 1'b0, 1, hs);
      wait_out(oc);
      check_trace("t6_trace", 1, 1);
      for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
      check_eq("final_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
